snn_step_scheduler: RTL and testbench

//  Sequences the SNN core from the SPI configuration block. Brings the SPI-domain

---
 rtl/snn_step_scheduler_if.sv | 29 ++
 rtl/snn_step_scheduler.sv | 134 +++++++++++++
 tb/tb_snn_step_scheduler.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/snn_step_scheduler_if.sv
// Bundles the configuration image, the SPI-domain ready flags and the
// scheduler outputs toward the SNN datapath.
//   master : SPI/config side (drives image and flags, observes outputs)
//   slave  : the step scheduler
interface snn_step_scheduler_if #(
    parameter int unsigned N_BYTES     = 80,
    parameter int unsigned SPIKE_BYTES = 1
);
    logic [N_BYTES*8-1:0]     all_data_in;
    logic                     clk_div_ready_in;
    logic                     input_spike_ready_in;
    logic                     debug_config_ready_in;
    logic                     step_en;
    logic [SPIKE_BYTES*8-1:0] spike_snapshot;
    logic [15:0]              step_count;
    logic                     busy;
    logic [7:0]               debug_sel;
    logic                     debug_valid;

    modport master (
        output all_data_in, clk_div_ready_in, input_spike_ready_in, debug_config_ready_in,
        input  step_en, spike_snapshot, step_count, busy, debug_sel, debug_valid
    );

    modport slave (
        input  all_data_in, clk_div_ready_in, input_spike_ready_in, debug_config_ready_in,
        output step_en, spike_snapshot, step_count, busy, debug_sel, debug_valid
    );
endinterface

// File: rtl/snn_step_scheduler.sv
// Step scheduler for the SNN core: synchronizes the SPI ready flags, loads the
// time-step divider, and emits periodic one-cycle step enables together with a
// snapshot of the input-spike bytes.
//   clk     : core clock
//   reset_n : asynchronous active-low reset
//   bus     : slave side of snn_step_scheduler_if (image, flags in; step_en,
//             spike_snapshot, step_count, busy, debug_sel, debug_valid out)
module snn_step_scheduler #(
    parameter int unsigned N_BYTES     = 80,
    parameter int unsigned DIV_IDX     = 0,
    parameter int unsigned SPIKE_IDX   = 1,
    parameter int unsigned SPIKE_BYTES = 1,
    parameter int unsigned DEBUG_IDX   = 79,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    snn_step_scheduler_if.slave  bus
);
    localparam int unsigned SNAP_W = SPIKE_BYTES * 8;

    typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SYNC_STAGES-1:0] r_div_sync, r_spk_sync, r_dbg_sync;
    logic                r_dbg_prev;
    logic [7:0]          r_cnt, w_cnt_nxt;
    logic [7:0]          r_div_q, w_div_nxt;
    logic                r_step_en, w_step_en_nxt;
    logic [15:0]         r_step_count, w_count_nxt;
    logic [SNAP_W-1:0]   r_snap, w_snap_nxt;
    logic                r_busy;
    logic [7:0]          r_debug_sel;
    logic                w_div_s, w_spk_s, w_dbg_s;
    logic                w_unused_bits;

    assign w_div_s = r_div_sync[SYNC_STAGES-1];
    assign w_spk_s = r_spk_sync[SYNC_STAGES-1];
    assign w_dbg_s = r_dbg_sync[SYNC_STAGES-1];

    // Only a few bytes of the image are consumed here.
    assign w_unused_bits = ^bus.all_data_in;

    // Ready-flag synchronizers and debug byte capture (independent of the FSM)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_sync  <= '0;
            r_spk_sync  <= '0;
            r_dbg_sync  <= '0;
            r_dbg_prev  <= 1'b0;
            r_debug_sel <= 8'd0;
        end else begin
            r_div_sync <= {r_div_sync[SYNC_STAGES-2:0], bus.clk_div_ready_in};
            r_spk_sync <= {r_spk_sync[SYNC_STAGES-2:0], bus.input_spike_ready_in};
            r_dbg_sync <= {r_dbg_sync[SYNC_STAGES-2:0], bus.debug_config_ready_in};
            r_dbg_prev <= w_dbg_s;
            if (w_dbg_s && !r_dbg_prev)
                r_debug_sel <= bus.all_data_in[DEBUG_IDX*8 +: 8];
        end
    end

    // FSM state and registered datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_cnt        <= 8'd0;
            r_div_q      <= 8'd0;
            r_step_en    <= 1'b0;
            r_step_count <= 16'd0;
            r_snap       <= '0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_div_q      <= w_div_nxt;
            r_step_en    <= w_step_en_nxt;
            r_step_count <= w_count_nxt;
            r_snap       <= w_snap_nxt;
            r_busy       <= (w_state_nxt == RUN);
        end
    end

    // Next state; losing the divider flag outranks losing the spike flag
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_div_nxt     = r_div_q;
        w_step_en_nxt = 1'b0;
        w_count_nxt   = r_step_count;
        w_snap_nxt    = r_snap;
        case (r_state)
            IDLE: begin
                if (w_div_s) begin
                    w_div_nxt   = bus.all_data_in[DIV_IDX*8 +: 8];
                    w_count_nxt = 16'd0;
                    w_state_nxt = ARMED;
                end
            end
            ARMED: begin
                if (!w_div_s) begin
                    w_state_nxt = IDLE;
                end else if (w_spk_s) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!w_div_s) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = IDLE;
                end else if (!w_spk_s) begin
                    w_cnt_nxt   = 8'd0;
                    w_state_nxt = ARMED;
                end else if (r_cnt == r_div_q) begin
                    w_cnt_nxt     = 8'd0;
                    w_step_en_nxt = 1'b1;
                    w_count_nxt   = r_step_count + 16'd1;
                    w_snap_nxt    = bus.all_data_in[SPIKE_IDX*8 +: SNAP_W];
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.step_en        = r_step_en;
    assign bus.spike_snapshot = r_snap;
    assign bus.step_count     = r_step_count;
    assign bus.busy           = r_busy;
    assign bus.debug_sel      = r_debug_sel;
    assign bus.debug_valid    = w_dbg_s;
endmodule

// File: tb/tb_snn_step_scheduler.sv
// Directed bench for snn_step_scheduler: divider load, step period, snapshot
// coherence, RUN exits, step_count wrap, debug capture and async reset.
module tb_snn_step_scheduler;
    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_err;

    snn_step_scheduler_if #(.N_BYTES(80), .SPIKE_BYTES(1)) bus ();

    snn_step_scheduler dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, then sample 1 time unit later
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_byte(input int idx, input logic [7:0] val);
        bus.all_data_in[idx*8 +: 8] = val;
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        bus.all_data_in           = '0;
        bus.clk_div_ready_in      = 1'b0;
        bus.input_spike_ready_in  = 1'b0;
        bus.debug_config_ready_in = 1'b0;
        cyc(2);
        check("rst_step_en",  32'(bus.step_en), 32'h0);
        check("rst_busy",     32'(bus.busy), 32'h0);
        check("rst_count",    32'(bus.step_count), 32'h0);
        check("rst_snapshot", 32'(bus.spike_snapshot), 32'h0);
        reset_n = 1'b1;
        cyc(1);

        // Test 1: divider 3 -> period 4
        set_byte(0, 8'd3);
        set_byte(1, 8'hA5);
        bus.clk_div_ready_in = 1'b1;
        cyc(3);
        check("armed_busy",  32'(bus.busy), 32'h0);
        check("armed_count", 32'(bus.step_count), 32'h0);
        bus.input_spike_ready_in = 1'b1;
        cyc(3);
        check("run_busy",    32'(bus.busy), 32'h1);
        check("run_entry_step", 32'(bus.step_en), 32'h0);
        cyc(3);
        check("pre_first_step", 32'(bus.step_en), 32'h0);
        cyc(1);
        check("first_step",  32'(bus.step_en), 32'h1);
        check("first_count", 32'(bus.step_count), 32'h1);
        check("first_snap",  32'(bus.spike_snapshot), 32'hA5);
        cyc(1);
        check("step_one_cycle", 32'(bus.step_en), 32'h0);
        cyc(2);
        check("step_gap", 32'(bus.step_en), 32'h0);
        cyc(1);
        check("second_step",  32'(bus.step_en), 32'h1);
        check("second_count", 32'(bus.step_count), 32'h2);

        // Test 3: snapshot holds until the next step edge
        set_byte(1, 8'h3C);
        cyc(1);
        check("snap_hold", 32'(bus.spike_snapshot), 32'hA5);
        cyc(3);
        check("third_step", 32'(bus.step_en), 32'h1);
        check("snap_new",   32'(bus.spike_snapshot), 32'h3C);
        check("third_count", 32'(bus.step_count), 32'h3);

        // Test 4: drop spike flag mid-period -> ARMED, count held
        bus.input_spike_ready_in = 1'b0;
        cyc(3);
        check("pause_busy",  32'(bus.busy), 32'h0);
        check("pause_step",  32'(bus.step_en), 32'h0);
        cyc(5);
        check("pause_step_later", 32'(bus.step_en), 32'h0);
        check("pause_count", 32'(bus.step_count), 32'h3);
        bus.input_spike_ready_in = 1'b1;
        cyc(3);
        check("resume_busy", 32'(bus.busy), 32'h1);
        cyc(3);
        check("resume_pre_step", 32'(bus.step_en), 32'h0);
        cyc(1);
        check("resume_step",  32'(bus.step_en), 32'h1);
        check("resume_count", 32'(bus.step_count), 32'h4);

        // Test 5: drop divider flag -> IDLE, reload divider 1 -> period 2
        bus.clk_div_ready_in     = 1'b0;
        bus.input_spike_ready_in = 1'b0;
        cyc(3);
        check("idle_busy",  32'(bus.busy), 32'h0);
        check("idle_step",  32'(bus.step_en), 32'h0);
        check("idle_count", 32'(bus.step_count), 32'h4);
        set_byte(0, 8'd1);
        bus.clk_div_ready_in = 1'b1;
        cyc(3);
        check("rearm_count", 32'(bus.step_count), 32'h0);
        bus.input_spike_ready_in = 1'b1;
        cyc(3);
        check("div1_busy", 32'(bus.busy), 32'h1);
        cyc(1);
        check("div1_gap0", 32'(bus.step_en), 32'h0);
        cyc(1);
        check("div1_step1", 32'(bus.step_en), 32'h1);
        check("div1_count1", 32'(bus.step_count), 32'h1);
        cyc(1);
        check("div1_gap1", 32'(bus.step_en), 32'h0);
        cyc(1);
        check("div1_step2", 32'(bus.step_en), 32'h1);
        check("div1_count2", 32'(bus.step_count), 32'h2);

        // Test 2: divider 0 -> step every cycle, then 16-bit wrap
        bus.clk_div_ready_in     = 1'b0;
        bus.input_spike_ready_in = 1'b0;
        cyc(3);
        set_byte(0, 8'd0);
        bus.clk_div_ready_in = 1'b1;
        cyc(3);
        bus.input_spike_ready_in = 1'b1;
        cyc(3);
        check("div0_count0", 32'(bus.step_count), 32'h0);
        cyc(1);
        check("div0_step1",  32'(bus.step_en), 32'h1);
        check("div0_count1", 32'(bus.step_count), 32'h1);
        cyc(1);
        check("div0_step2",  32'(bus.step_en), 32'h1);
        check("div0_count2", 32'(bus.step_count), 32'h2);
        cyc(65533);
        check("div0_step_held", 32'(bus.step_en), 32'h1);
        check("count_ffff",  32'(bus.step_count), 32'hFFFF);
        cyc(1);
        check("count_wrap",  32'(bus.step_count), 32'h0);
        cyc(1);
        check("count_after_wrap", 32'(bus.step_count), 32'h1);

        // Test 6: debug capture on rising synced flag
        set_byte(79, 8'h5A);
        bus.debug_config_ready_in = 1'b1;
        cyc(2);
        check("dbg_valid", 32'(bus.debug_valid), 32'h1);
        check("dbg_sel_early", 32'(bus.debug_sel), 32'h0);
        cyc(1);
        check("dbg_sel", 32'(bus.debug_sel), 32'h5A);
        set_byte(79, 8'h11);
        cyc(2);
        check("dbg_sel_no_reload", 32'(bus.debug_sel), 32'h5A);
        bus.debug_config_ready_in = 1'b0;
        cyc(2);
        check("dbg_valid_low", 32'(bus.debug_valid), 32'h0);
        check("dbg_sel_held", 32'(bus.debug_sel), 32'h5A);

        // Async reset mid-RUN, observed before any clock edge
        check("pre_reset_busy", 32'(bus.busy), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_step_en", 32'(bus.step_en), 32'h0);
        check("arst_busy",    32'(bus.busy), 32'h0);
        check("arst_count",   32'(bus.step_count), 32'h0);
        check("arst_snap",    32'(bus.spike_snapshot), 32'h0);
        check("arst_dbg_sel", 32'(bus.debug_sel), 32'h0);
        cyc(2);
        check("rst_hold_step", 32'(bus.step_en), 32'h0);
        reset_n = 1'b1;
        cyc(2);
        check("post_rst_busy", 32'(bus.busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
